// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
// Holds the FSM state encoding and default parameter values.
package pulse_meter_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on a clk-synchronous level.
// rise is high for the single cycle where in goes 0 -> 1.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= in;
    end
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive pulse rising edges and
// hands each result to a consumer over a valid/ready pair.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  meter_state_t     state;
  logic [WIDTH-1:0] count;
  logic             rise;
  logic             hit;
  logic             emit;
  logic             take;
  logic             load;
  logic             drop;
  logic             clear;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (pulse),
    .rise (rise)
  );

  assign hit  = (count == LIMIT);
  assign emit = en && rise && (state == S_MEASURE);
  assign take = period_valid && period_ready;
  assign load = emit && (!period_valid || period_ready);
  assign drop = emit && period_valid && !period_ready;
  assign clear = take && !emit;

  // An edge always wins over a coincident timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      count   <= '0;
      timeout <= 1'b0;
    end else if (!en) begin
      state   <= S_IDLE;
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_ARMED;
          count <= '0;
        end
        S_ARMED: begin
          if (rise) begin
            state   <= S_MEASURE;
            count   <= ONE;
            timeout <= 1'b0;
          end else if (hit) begin
            count   <= '0;
            timeout <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            count   <= ONE;
            timeout <= 1'b0;
          end else if (hit) begin
            state   <= S_ARMED;
            count   <= '0;
            timeout <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      unique case (1'b1)
        load: begin
          period       <= count;
          period_valid <= 1'b1;
        end
        drop: begin
          overrun <= 1'b1;
        end
        clear: begin
          period_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of period result and internal counter.
REQ-002 SHALL have parameter TIMEOUT, default 1000: cycles without a pulse edge before timeout; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1: measurement enable.
REQ-006 SHALL have port pulse  input  1: terminal-count pulse from counter_8, synchronous to clk.
REQ-007 SHALL have port period  output  WIDTH: measured cycles between consecutive pulse rising edges.
REQ-008 SHALL have port period_valid  output  1: period holds an unconsumed result.
REQ-009 SHALL have port period_ready  input  1: consumer accepts result.
REQ-010 SHALL have port timeout  output  1: level, no edge seen within TIMEOUT cycles.
REQ-011 SHALL have port overrun  output  1: sticky, a result was dropped.

Function
REQ-012 SHALL detect a rising edge as pulse==1 this cycle and pulse==0 in the previous sampled cycle; a multi-cycle-high pulse counts as one edge.
REQ-013 SHALL implement states IDLE, ARMED, MEASURE.
REQ-014 IDLE: en==0 -> stay IDLE, counter held at 0; en==1 -> ARMED next cycle.
REQ-015 ARMED: first edge -> MEASURE, counter loaded with 1, no result emitted.
REQ-016 MEASURE: counter increments by 1 each cycle without an edge.
REQ-017 MEASURE edge: result = current counter value, counter reloaded with 1, remain in MEASURE.
REQ-018 Period semantics: edges sampled at cycles t and t+P SHALL yield period==P.
REQ-019 period_valid SHALL rise on the clock edge after the edge-sampling cycle; latency 1 cycle.
REQ-020 period and period_valid SHALL hold stable while period_valid==1 and period_ready==0.
REQ-021 Transfer occurs when period_valid==1 and period_ready==1; period_valid deasserts next cycle unless a new result loads in the same cycle.
REQ-022 New result with transfer in the same cycle SHALL load; period_valid stays 1, period updates.
REQ-023 New result while period_valid==1 and period_ready==0 SHALL be dropped, old result kept, overrun set to 1.
REQ-024 MEASURE or ARMED with counter reaching TIMEOUT and no edge -> timeout=1, state ARMED, counter 0; next edge restarts as REQ-015.
REQ-025 timeout SHALL clear on the cycle after the next detected edge or when en==0.
REQ-026 en==0 in any state SHALL return to IDLE next cycle, abort the measurement in progress, and leave a pending result and overrun untouched.
REQ-027 Edge and timeout in the same cycle: edge SHALL win, result emitted, no timeout.

Reset
REQ-028 With rst==0 at a rising clk edge: state IDLE, counter 0, period 0, period_valid 0, timeout 0, overrun 0, edge history 0.
REQ-029 Reset mid-measurement SHALL discard any pending result; no partial period emitted after reset release.
REQ-030 overrun SHALL clear only by reset.

Structure
REQ-031 Package pulse_meter_pkg SHALL hold the state enum and default WIDTH/TIMEOUT constants.
REQ-032 Rising-edge detection SHALL be a sub-module edge_detect (clk, rst, in, rise), reusable by one_shot-style blocks.

Verification
REQ-033 en=1, pulse one cycle high every 16 cycles -> first edge no result; each later edge yields period=16, valid 1 cycle after the edge.
REQ-034 pulse held high 5 cycles, repeated every 20 cycles -> period=20, one result per high phase.
REQ-035 period_ready=0, two edges 10 apart after a pending result -> first result held, overrun=1, period unchanged.
REQ-036 TIMEOUT=50, no edge for 50 cycles in MEASURE -> timeout=1 at counter 50; next edge clears timeout, no result; following edge 8 later -> period=8.
REQ-037 rst=0 asserted mid-MEASURE with period_valid=1 -> next cycle all outputs 0, state IDLE.
REQ-038 Edge coinciding with transfer (ready=1, valid=1) -> valid stays 1, period takes the new value, overrun stays 0.
